// File: rtl/rtc_pkg.sv
// Shared types for the RTC access scheduler: FSM states, grant kinds and sizing helpers.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // Grant code doubles as the bit index into the pending and command vectors.
  typedef enum logic [1:0] {
    GNT_INIT   = 2'd0,
    GNT_WRITE  = 2'd1,
    GNT_FORMAT = 2'd2,
    GNT_READ   = 2'd3
  } gnt_t;

  // Bits needed to hold the values 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [3:0] gnt_onehot(input gnt_t g);
    return 4'b0001 << g;
  endfunction

endpackage

// File: rtl/rtc_periodic_tick.sv
// Free-running 0..PERIOD-1 counter; tick is high for the single cycle the count sits at PERIOD-1.
module rtc_periodic_tick
  import rtc_pkg::*;
#(
  parameter int PERIOD = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = clog2(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/rtc_access_scheduler.sv
// Chooses the next RTC sequencer transaction (init/write/format/read), holds its command level
// until completion or watchdog expiry, then forces an idle gap before the next grant.
module rtc_access_scheduler
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD    = 1000000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_init,
  input  logic req_write,
  input  logic req_format,
  input  logic read_en,
  input  logic clear_err,
  input  logic seq_done,
  output logic cmd_init,
  output logic cmd_write,
  output logic cmd_format,
  output logic cmd_read,
  output logic busy,
  output logic read_done,
  output logic timeout_err,
  output logic read_overrun
);

  localparam int WD_W  = clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = clog2(GAP_CYCLES);
  // The ISSUE cycle counts toward the command lifetime, so WAIT expires one count early.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  sched_state_t state, state_n;
  gnt_t         gnt, gnt_n;
  logic [3:0]   pend, pend_n, pend_clr;
  logic [3:0]   cmd, cmd_n;
  logic [WD_W-1:0]  wdog, wdog_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic read_done_n, timeout_set, overrun_set;
  logic read_tick, read_req, read_keep;

  rtc_periodic_tick #(.PERIOD(READ_PERIOD)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (read_tick)
  );

  // A request landing in the cycle its bit is cleared for grant survives as a new request.
  assign read_req    = read_tick & read_en;
  assign read_keep   = pend[GNT_READ] & ~pend_clr[GNT_READ];
  assign overrun_set = read_req & read_keep;
  assign pend_n      = (pend & ~pend_clr) | {read_req, req_format, req_write, req_init};

  // Handshake: cmd_* is a registered level, one-hot, raised on entry to ISSUE and held through
  // WAIT; seq_done is a one-cycle pulse honoured only in WAIT, and cmd_* falls the cycle after it
  // (or after watchdog expiry). seq_done in any other state is ignored.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    cmd_n       = cmd;
    wdog_n      = wdog;
    gcnt_n      = gcnt;
    pend_clr    = '0;
    read_done_n = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|pend) begin
          if (pend[GNT_INIT])        gnt_n = GNT_INIT;
          else if (pend[GNT_WRITE])  gnt_n = GNT_WRITE;
          else if (pend[GNT_FORMAT]) gnt_n = GNT_FORMAT;
          else                       gnt_n = GNT_READ;
          pend_clr = gnt_onehot(gnt_n);
          cmd_n    = gnt_onehot(gnt_n);
          state_n  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_n = wdog + WD_W'(1);
        if (seq_done) begin
          cmd_n       = '0;
          read_done_n = (gnt == GNT_READ);
          gcnt_n      = '0;
          state_n     = ST_GAP;
        end else if (wdog == WD_LAST) begin
          cmd_n       = '0;
          timeout_set = 1'b1;
          gcnt_n      = '0;
          state_n     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gcnt == GAP_LAST) state_n = ST_IDLE;
        else                  gcnt_n  = gcnt + GAP_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      gnt          <= GNT_INIT;
      pend         <= '0;
      cmd          <= '0;
      wdog         <= '0;
      gcnt         <= '0;
      read_done    <= 1'b0;
      timeout_err  <= 1'b0;
      read_overrun <= 1'b0;
    end else begin
      state        <= state_n;
      gnt          <= gnt_n;
      pend         <= pend_n;
      cmd          <= cmd_n;
      wdog         <= wdog_n;
      gcnt         <= gcnt_n;
      read_done    <= read_done_n;
      timeout_err  <= timeout_set | (timeout_err & ~clear_err);
      read_overrun <= overrun_set | (read_overrun & ~clear_err);
    end
  end

  assign cmd_init   = cmd[GNT_INIT];
  assign cmd_write  = cmd[GNT_WRITE];
  assign cmd_format = cmd[GNT_FORMAT];
  assign cmd_read   = cmd[GNT_READ];
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: directed scenarios plus random traffic against a
// transaction-timestamp reference model.
module tb_rtc_access_scheduler;

  localparam int P = 16;
  localparam int T = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_init = 1'b0, req_write = 1'b0, req_format = 1'b0;
  logic read_en = 1'b0, clear_err = 1'b0, seq_done = 1'b0;
  logic cmd_init, cmd_write, cmd_format, cmd_read;
  logic busy, read_done, timeout_err, read_overrun;

  rtc_access_scheduler #(
    .READ_PERIOD    (P),
    .TIMEOUT_CYCLES (T),
    .GAP_CYCLES     (G)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_init     (req_init),
    .req_write    (req_write),
    .req_format   (req_format),
    .read_en      (read_en),
    .clear_err    (clear_err),
    .seq_done     (seq_done),
    .cmd_init     (cmd_init),
    .cmd_write    (cmd_write),
    .cmd_format   (cmd_format),
    .cmd_read     (cmd_read),
    .busy         (busy),
    .read_done    (read_done),
    .timeout_err  (timeout_err),
    .read_overrun (read_overrun)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {cmd_init, cmd_write, cmd_format, cmd_read, busy, read_done, timeout_err, read_overrun};
  wire [3:0] cur = {cmd_read, cmd_format, cmd_write, cmd_init};

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: each transaction is a time window [issue, end]; the scheduler is free again
  // GAP cycles after the window closes.
  int       m_cnt = 0;
  bit [3:0] m_pend = '0;
  bit       m_active = 0;
  int       m_gnt = 0, m_issue = 0, m_idle_at = 0;
  bit       m_to = 0, m_ov = 0;
  logic [7:0] exp_v = '0;

  // Sequencer responder
  int seq_lat = -1;
  bit rand_lat = 0, spurious = 0, prev_any = 0;
  int rise_cyc = 0;

  logic [1:0] exp_q[$];

  task automatic model_edge();
    bit tick, idle_now, done_now, to_now, rd_now, ov_set;
    if (reset) begin
      m_cnt = 0; m_pend = '0; m_active = 0; m_idle_at = cyc + 1;
      m_to = 0; m_ov = 0; exp_v = '0;
      return;
    end
    tick = (m_cnt == P - 1);
    m_cnt = (m_cnt + 1) % P;
    idle_now = !m_active && (cyc >= m_idle_at);
    done_now = 0; to_now = 0;
    if (m_active && cyc >= m_issue + 1) begin
      if (seq_done) done_now = 1;
      else if (cyc == m_issue + T - 1) to_now = 1;
    end
    rd_now = done_now && (m_gnt == 3);
    if (done_now || to_now) begin
      m_active = 0;
      m_idle_at = cyc + 1 + G;
    end
    if (idle_now) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && !m_active) begin
          m_active = 1; m_gnt = i; m_issue = cyc + 1; m_pend[i] = 0;
        end
      end
    end
    if (req_init)   m_pend[0] = 1;
    if (req_write)  m_pend[1] = 1;
    if (req_format) m_pend[2] = 1;
    ov_set = 0;
    if (tick && read_en) begin
      if (m_pend[3]) ov_set = 1;
      else m_pend[3] = 1;
    end
    m_to = to_now ? 1'b1 : (clear_err ? 1'b0 : m_to);
    m_ov = ov_set ? 1'b1 : (clear_err ? 1'b0 : m_ov);
    exp_v = {m_active && m_gnt == 0, m_active && m_gnt == 1, m_active && m_gnt == 2,
             m_active && m_gnt == 3, m_active || (cyc + 1 < m_idle_at), rd_now, m_to, m_ov};
  endtask

  task automatic step();
    bit any_cmd;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    req_init = 0; req_write = 0; req_format = 0; clear_err = 0;
    any_cmd = cmd_init | cmd_write | cmd_format | cmd_read;
    if (any_cmd && !prev_any) begin
      rise_cyc = cyc;
      if (rand_lat) seq_lat = $urandom_range(0, 9);
    end
    prev_any = any_cmd;
    seq_done = any_cmd && (seq_lat >= 0) && (cyc - rise_cyc == seq_lat);
    if (spurious && !any_cmd && $urandom_range(0, 9) == 0) seq_done = 1;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  function automatic int rise_code(input logic [3:0] prev, input logic [3:0] now);
    for (int k = 0; k < 4; k++) if (now[k] && !prev[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1; read_en = 1; req_init = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_run++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs cyc=%0d got=%b exp=00000000", cyc, obs); end
    end
    reset = 0; read_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_periodic_read();
    int rel, first_rise, last_rise, n_rise, n_rd;
    bit prev_rd;
    read_en = 1; seq_lat = 3; rand_lat = 0; spurious = 0;
    do_reset();
    rel = cyc; first_rise = -1; last_rise = -1; n_rise = 0; n_rd = 0; prev_rd = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL periodic_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (cmd_read && !prev_rd) begin
        if (first_rise < 0) first_rise = cyc - rel;
        last_rise = cyc - rel;
        n_rise++;
      end
      prev_rd = cmd_read;
      if (read_done) n_rd++;
    end
    n_run++;
    if (first_rise != 17) begin n_fail++; $display("FAIL periodic_first_rise got=%0d exp=17", first_rise); end
    n_run++;
    if (n_rise != 3 || last_rise != 49) begin n_fail++; $display("FAIL periodic_spacing got=%0d rises last=%0d exp=3 rises last=49", n_rise, last_rise); end
    n_run++;
    if (n_rd != 3) begin n_fail++; $display("FAIL periodic_read_done got=%0d exp=3", n_rd); end
  endtask

  task automatic test_write_format();
    int lat, t_pulse, r_w, r_f, rc;
    logic [3:0] prev_cmd;
    logic [1:0] exp_g;
    read_en = 0; lat = $urandom_range(1, 5); seq_lat = lat;
    do_reset();
    t_pulse = cyc; req_write = 1; req_format = 1;
    exp_q = {2'd1, 2'd2}; r_w = -1; r_f = -1; prev_cmd = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL wf_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      n_run++;
      if ($countones(cur) > 1) begin n_fail++; $display("FAIL wf_onehot cyc=%0d got=%b exp=at most one", cyc, cur); end
      rc = rise_code(prev_cmd, cur);
      if (rc == 1) r_w = cyc;
      if (rc == 2) r_f = cyc;
      if (rc >= 0) begin
        n_run++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wf_order cyc=%0d got=%0d exp=none", cyc, rc); end
        else begin
          exp_g = exp_q.pop_front();
          if (rc != int'(exp_g)) begin n_fail++; $display("FAIL wf_order cyc=%0d got=%0d exp=%0d", cyc, rc, exp_g); end
        end
      end
      prev_cmd = cur;
    end
    n_run++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wf_missing got=%0d left exp=0", exp_q.size()); end
    n_run++;
    if (r_w - t_pulse != 2) begin n_fail++; $display("FAIL wf_latency got=%0d exp=2", r_w - t_pulse); end
    n_run++;
    if (r_f - r_w != lat + 4) begin n_fail++; $display("FAIL wf_gap got=%0d exp=%0d", r_f - r_w, lat + 4); end
  endtask

  task automatic test_init_priority();
    int rel, r_i, rc;
    logic [3:0] prev_cmd;
    logic [1:0] exp_g;
    read_en = 1; seq_lat = 4;
    do_reset();
    rel = cyc; r_i = -1; prev_cmd = '0;
    exp_q = {2'd1, 2'd0, 2'd3};
    for (int i = 0; i < 34; i++) begin
      if (cyc == rel + 10) req_write = 1;
      if (cyc == rel + 13) req_init = 1;
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL prio_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      rc = rise_code(prev_cmd, cur);
      if (rc == 0) r_i = cyc - rel;
      if (rc >= 0) begin
        n_run++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL prio_order cyc=%0d got=%0d exp=none", cyc, rc); end
        else begin
          exp_g = exp_q.pop_front();
          if (rc != int'(exp_g)) begin n_fail++; $display("FAIL prio_order cyc=%0d got=%0d exp=%0d", cyc, rc, exp_g); end
        end
      end
      prev_cmd = cur;
    end
    n_run++;
    if (r_i != 20) begin n_fail++; $display("FAIL prio_init_time got=%0d exp=20", r_i); end
    n_run++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL prio_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int p, n_hi, r_w;
    bit prev_w;
    read_en = 0; seq_lat = -1;
    do_reset();
    step();
    p = cyc; req_format = 1; n_hi = 0; r_w = -1; prev_w = 0;
    for (int i = 0; i < 40; i++) begin
      if (cyc == p + 3) req_write = 1;
      if (cyc == p + 25) clear_err = 1;
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL to_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (cmd_format) n_hi++;
      if (cmd_write && !prev_w) r_w = cyc - p;
      prev_w = cmd_write;
      if (cyc == p + 10) begin
        seq_lat = 2;
        n_run++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag_set got=%b exp=1", timeout_err); end
      end
      if (cyc == p + 25) begin
        n_run++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag_sticky got=%b exp=1", timeout_err); end
      end
      if (cyc == p + 26) begin
        n_run++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_flag_clear got=%b exp=0", timeout_err); end
      end
    end
    n_run++;
    if (n_hi != 8) begin n_fail++; $display("FAIL to_hold_cycles got=%0d exp=8", n_hi); end
    n_run++;
    if (r_w != 13) begin n_fail++; $display("FAIL to_next_served got=%0d exp=13", r_w); end
  endtask

  task automatic test_overrun();
    int rel, n_rd, r_rd;
    bit prev_rd;
    read_en = 1; seq_lat = 5;
    do_reset();
    rel = cyc; n_rd = 0; r_rd = -1; prev_rd = 0;
    for (int i = 0; i < 62; i++) begin
      if (cyc - rel <= 43) req_write = 1;
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL ovr_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (cmd_read && !prev_rd) begin n_rd++; r_rd = cyc - rel; end
      prev_rd = cmd_read;
      if (cyc == rel + 31) begin
        n_run++;
        if (read_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got=%b exp=0", read_overrun); end
      end
    end
    n_run++;
    if (read_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", read_overrun); end
    n_run++;
    if (n_rd != 1 || r_rd != 56) begin n_fail++; $display("FAIL ovr_single_read got=%0d reads at %0d exp=1 at 56", n_rd, r_rd); end
  endtask

  task automatic test_reset_mid();
    int rel, n_w;
    read_en = 1; seq_lat = -1;
    do_reset();
    rel = cyc; n_w = 0;
    for (int i = 0; i < 20; i++) begin
      if (cyc == rel + 18) req_write = 1;
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rmid_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
    n_run++;
    if (cmd_read !== 1'b1) begin n_fail++; $display("FAIL rmid_read_active got=%b exp=1", cmd_read); end
    reset = 1;
    step();
    n_run++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL rmid_drop got=%b exp=00000000", obs); end
    reset = 0; read_en = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rmid_after cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (cmd_write) n_w++;
    end
    n_run++;
    if (n_w != 0) begin n_fail++; $display("FAIL rmid_no_write got=%0d exp=0", n_w); end
  endtask

  task automatic test_random();
    rand_lat = 1; spurious = 1; read_en = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_init   = ($urandom_range(0, 39) == 0);
      req_write  = ($urandom_range(0, 11) == 0);
      req_format = ($urandom_range(0, 14) == 0);
      clear_err  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) read_en = ~read_en;
      reset = ($urandom_range(0, 249) == 0);
      step();
      n_run++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      n_run++;
      if ($countones(cur) > 1) begin n_fail++; $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one", cyc, cur); end
    end
    reset = 0; rand_lat = 0; spurious = 0;
  endtask

  initial begin
    test_reset();
    test_periodic_read();
    test_write_format();
    test_init_priority();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
